fifo_burst_reader: RTL and testbench

- Read-side consumer for the team's 32-bit synchronous FIFO (w_en/r_en, full/empty, registered data_out).
- On a start command, pops exactly xfer_len words from the FIFO and re-presents them as a valid/ready stream with a last-word marker.
- A 2-entry skid buffer absorbs the FIFO's 1-cycle read latency and downstream backpressure.
- Sits between the FIFO read port and any stream consumer (DMA, serializer).

---
 rtl/fifo_burst_reader_if.sv | 29 ++
 rtl/fifo_burst_reader.sv | 101 ++++++++++
 tb/tb_fifo_burst_reader.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_reader_if.sv
// Handshake bundle for fifo_burst_reader: command/status, FIFO read port and output stream.
// master = the burst reader, slave = the surrounding FIFO/consumer/controller.
interface fifo_burst_reader_if #(
  parameter int DW = 32,
  parameter int LW = 16
);
  logic          start;
  logic [LW-1:0] xfer_len;
  logic          busy;
  logic          done;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rdata;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [LW-1:0] words_left;

  modport master (
    input  start, xfer_len, fifo_empty, fifo_rdata, m_ready,
    output busy, done, fifo_rd_en, m_valid, m_data, m_last, words_left
  );

  modport slave (
    output start, xfer_len, fifo_empty, fifo_rdata, m_ready,
    input  busy, done, fifo_rd_en, m_valid, m_data, m_last, words_left
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Pops xfer_len words from a registered-output FIFO and re-presents them as a
// valid/ready stream with a last marker, through a 2-entry skid buffer.
module fifo_burst_reader #(
  parameter int DW = 32,
  parameter int LW = 16
) (
  input  logic                clk,
  input  logic                rst,
  fifo_burst_reader_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] issue_cnt;
  logic [LW-1:0] words_left;
  logic [DW-1:0] buf0, buf1;
  logic [1:0]    buf_cnt;
  logic          inflight;
  logic          zero_done_q;
  logic          m_valid, acc, rd_en, room, start_go;
  logic [2:0]    occ;

  assign start_go = (state_q == IDLE) && bus.start;
  assign m_valid  = (buf_cnt != 2'd0);
  assign acc      = m_valid && bus.m_ready;
  // Slots committed = buffered + in flight; a word leaving this cycle frees one,
  // which keeps back-to-back pops going at full rate.
  assign occ      = {1'b0, buf_cnt} + {2'b0, inflight};
  assign room     = occ < (3'd2 + {2'b0, acc});
  assign rd_en    = (state_q == RUN) && (issue_cnt != '0) && !bus.fifo_empty && room;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_go && (bus.xfer_len != '0)) state_d = RUN;
      RUN:     if (acc && (words_left == LW'(1))) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      issue_cnt   <= '0;
      words_left  <= '0;
      inflight    <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      inflight    <= rd_en;
      zero_done_q <= start_go && (bus.xfer_len == '0);
      if (start_go) begin
        issue_cnt  <= bus.xfer_len;
        words_left <= bus.xfer_len;
      end else begin
        if (rd_en) issue_cnt  <= issue_cnt - LW'(1);
        if (acc)   words_left <= words_left - LW'(1);
      end
    end
  end

  // Skid buffer: buf0 is always the head; the word from last cycle's pop lands
  // behind whatever survives this cycle's acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf0    <= '0;
      buf1    <= '0;
      buf_cnt <= 2'd0;
    end else begin
      unique case ({acc, inflight})
        2'b11: begin
          if (buf_cnt == 2'd2) begin
            buf0 <= buf1;
            buf1 <= bus.fifo_rdata;
          end else begin
            buf0 <= bus.fifo_rdata;
          end
        end
        2'b10: begin
          if (buf_cnt == 2'd2) buf0 <= buf1;
          buf_cnt <= buf_cnt - 2'd1;
        end
        2'b01: begin
          if (buf_cnt == 2'd0) buf0 <= bus.fifo_rdata;
          else                 buf1 <= bus.fifo_rdata;
          buf_cnt <= buf_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == FIN) || zero_done_q;
  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = m_valid;
  assign bus.m_data     = buf0;
  assign bus.m_last     = m_valid && (words_left == LW'(1));
  assign bus.words_left = words_left;
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: behavioural registered-output FIFO,
// acceptance monitor, and per-cycle traces compared against hand-derived vectors.
module tb_fifo_burst_reader;
  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] xfer_len;
  logic        m_ready;
  logic        flush;

  fifo_burst_reader_if #(.DW(32), .LW(16)) bus ();

  fifo_burst_reader #(.DW(32), .LW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: data_out registered on an accepted pop
  logic [31:0] mem [0:4095];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic [31:0] fifo_q = '0;

  assign bus.start      = start;
  assign bus.xfer_len   = xfer_len;
  assign bus.m_ready    = m_ready;
  assign bus.fifo_empty = (wr_ptr == rd_ptr);
  assign bus.fifo_rdata = fifo_q;

  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (bus.fifo_rd_en) begin
      fifo_q <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Monitor: samples mid-cycle once inputs have settled
  logic [31:0] cap_mem [0:4095];
  int          cap_n = 0, done_cnt = 0, last_cnt = 0, pop_cnt = 0;
  int          occ_viol = 0, stall_viol = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      if (bus.m_valid && bus.m_ready) begin
        cap_mem[cap_n] <= bus.m_data;
        cap_n <= cap_n + 1;
        if (bus.m_last) last_cnt <= last_cnt + 1;
      end
      if (bus.done) done_cnt <= done_cnt + 1;
      if (bus.fifo_rd_en) pop_cnt <= pop_cnt + 1;
      if (({1'b0, dut.buf_cnt} + {2'b0, dut.inflight}) > 3'd2) occ_viol <= occ_viol + 1;
      if (prev_stall && (!bus.m_valid || (bus.m_data !== prev_data))) stall_viol <= stall_viol + 1;
      prev_stall <= bus.m_valid && !bus.m_ready;
      prev_data  <= bus.m_data;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] tr_rd, tr_v, tr_last, tr_done, tr_busy;
  logic [31:0] rdy_pat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d);
    mem[wr_ptr] = d;
    wr_ptr++;
  endtask

  task automatic trace(input int n);
    tr_rd = '0; tr_v = '0; tr_last = '0; tr_done = '0; tr_busy = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      start   = 1'b0;
      m_ready = rdy_pat[k];
      #3;
      tr_rd[k]   = bus.fifo_rd_en;
      tr_v[k]    = bus.m_valid;
      tr_last[k] = bus.m_last;
      tr_done[k] = bus.done;
      tr_busy[k] = bus.busy;
    end
  endtask

  int          base, wbase, dbase, lbase, pbase, errs;
  logic        got3, fin;

  initial begin
    rst = 1'b0; start = 1'b0; xfer_len = '0; m_ready = 1'b0; flush = 1'b0;
    rdy_pat = '1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy",   32'(bus.busy), 32'd0);
    chk("rst_done",   32'(bus.done), 32'd0);
    chk("rst_rd_en",  32'(bus.fifo_rd_en), 32'd0);
    chk("rst_valid",  32'(bus.m_valid), 32'd0);
    chk("rst_data",   bus.m_data, 32'd0);
    chk("rst_last",   32'(bus.m_last), 32'd0);
    chk("rst_wleft",  32'(bus.words_left), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Basic burst
    base = cap_n;
    for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
    m_ready = 1'b1; xfer_len = 16'd4; start = 1'b1;
    trace(8);
    chk("basic_rd_en", tr_rd[7:0],   32'h0F);
    chk("basic_valid", tr_v[7:0],    32'h3C);
    chk("basic_last",  tr_last[7:0], 32'h20);
    chk("basic_done",  tr_done[7:0], 32'h40);
    chk("basic_busy",  tr_busy[7:0], 32'h7F);
    chk("basic_count", 32'(cap_n - base), 32'd4);
    for (int i = 0; i < 4; i++) chk("basic_data", cap_mem[base + i], 32'hA0 + 32'(i));

    // Backpressure with ready pattern 1,0,0,1 repeating
    base = cap_n;
    for (int i = 0; i < 6; i++) push(32'hB0 + 32'(i));
    rdy_pat = 32'h9999_9999;
    xfer_len = 16'd6; start = 1'b1;
    trace(30);
    chk("bp_count", 32'(cap_n - base), 32'd6);
    for (int i = 0; i < 6; i++) chk("bp_data", cap_mem[base + i], 32'hB0 + 32'(i));
    chk("bp_last",  32'($countones(tr_last & tr_v & rdy_pat)), 32'd1);
    chk("bp_done",  32'($countones(tr_done)), 32'd1);
    chk("bp_idle",  32'(bus.busy), 32'd0);
    chk("bp_stall", 32'(stall_viol), 32'd0);
    chk("bp_occ",   32'(occ_viol), 32'd0);
    rdy_pat = '1;

    // Underrun: 2 of 5 words available, rest arrive later
    base = cap_n;
    push(32'hC0); push(32'hC1);
    xfer_len = 16'd5; start = 1'b1;
    trace(10);
    chk("ur_rd_first", tr_rd[1:0], 32'h3);
    chk("ur_rd_gap",   tr_rd[9:2], 32'h0);
    chk("ur_v_first",  tr_v[3:0],  32'hC);
    chk("ur_v_gap",    tr_v[9:4],  32'h0);
    chk("ur_wleft",    32'(bus.words_left), 32'd3);
    chk("ur_busy",     32'(bus.busy), 32'd1);
    push(32'hC2); push(32'hC3); push(32'hC4);
    trace(12);
    chk("ur_rd_resume", 32'(tr_rd[0]), 32'd1);
    chk("ur_done",  32'($countones(tr_done)), 32'd1);
    chk("ur_wleft_end", 32'(bus.words_left), 32'd0);
    chk("ur_count", 32'(cap_n - base), 32'd5);
    for (int i = 0; i < 5; i++) chk("ur_data", cap_mem[base + i], 32'hC0 + 32'(i));

    // Zero length
    pbase = pop_cnt;
    xfer_len = 16'd0; start = 1'b1;
    trace(3);
    chk("zl_done", tr_done[2:0], 32'h1);
    chk("zl_busy", tr_busy[2:0], 32'h0);
    chk("zl_rd",   tr_rd[2:0],   32'h0);
    chk("zl_pops", 32'(pop_cnt - pbase), 32'd0);

    // Start during RUN is ignored
    base = cap_n; pbase = pop_cnt;
    push(32'hD0); push(32'hD1); push(32'hD2);
    xfer_len = 16'd3; start = 1'b1;
    trace(2);
    xfer_len = 16'd9; start = 1'b1;
    trace(12);
    chk("ign_done",  32'($countones(tr_done)), 32'd1);
    chk("ign_busy",  32'(bus.busy), 32'd0);
    chk("ign_pops",  32'(pop_cnt - pbase), 32'd3);
    chk("ign_count", 32'(cap_n - base), 32'd3);
    for (int i = 0; i < 3; i++) chk("ign_data", cap_mem[base + i], 32'hD0 + 32'(i));

    // Async reset mid-burst, dropped between edges on word 3
    base = cap_n; dbase = done_cnt;
    for (int i = 0; i < 8; i++) push(32'hE0 + 32'(i));
    xfer_len = 16'd8; start = 1'b1;
    got3 = 1'b0;
    for (int k = 0; k < 40 && !got3; k++) begin
      @(negedge clk);
      start = 1'b0;
      #3;
      if (cap_n - base >= 3) got3 = 1'b1;
    end
    chk("ar_reach_w3", 32'(got3), 32'd1);
    rst = 1'b0;
    #1;
    chk("ar_busy",  32'(bus.busy), 32'd0);
    chk("ar_done",  32'(bus.done), 32'd0);
    chk("ar_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    chk("ar_valid", 32'(bus.m_valid), 32'd0);
    chk("ar_data",  bus.m_data, 32'd0);
    chk("ar_last",  32'(bus.m_last), 32'd0);
    chk("ar_wleft", 32'(bus.words_left), 32'd0);
    flush = 1'b1;
    repeat (2) @(negedge clk);
    flush = 1'b0;
    rst = 1'b1;
    chk("ar_no_done", 32'(done_cnt - dbase), 32'd0);
    base = cap_n;
    push(32'hF0); push(32'hF1);
    xfer_len = 16'd2; start = 1'b1;
    trace(8);
    chk("ar2_rd",    tr_rd[7:0], 32'h03);
    chk("ar2_done",  32'($countones(tr_done)), 32'd1);
    chk("ar2_count", 32'(cap_n - base), 32'd2);
    chk("ar2_d0",    cap_mem[base], 32'hF0);
    chk("ar2_d1",    cap_mem[base + 1], 32'hF1);

    // Full-rate stress, random ready
    base = cap_n; wbase = wr_ptr; dbase = done_cnt; lbase = last_cnt;
    for (int i = 0; i < 1000; i++) push($urandom);
    xfer_len = 16'd1000; start = 1'b1;
    fin = 1'b0;
    for (int k = 0; k < 6000 && !fin; k++) begin
      @(negedge clk);
      start   = 1'b0;
      m_ready = 1'($urandom_range(0, 1));
      #3;
      if (!bus.busy) fin = 1'b1;
    end
    chk("st_finished", 32'(fin), 32'd1);
    m_ready = 1'b1;
    repeat (4) @(negedge clk);
    #3;
    errs = 0;
    for (int i = 0; i < 1000; i++)
      if (cap_mem[base + i] !== mem[wbase + i]) errs++;
    chk("st_count", 32'(cap_n - base), 32'd1000);
    chk("st_data",  32'(errs), 32'd0);
    chk("st_last",  32'(last_cnt - lbase), 32'd1);
    chk("st_done",  32'(done_cnt - dbase), 32'd1);
    chk("st_occ",   32'(occ_viol), 32'd0);
    chk("st_stall", 32'(stall_viol), 32'd0);
    chk("st_wleft", 32'(bus.words_left), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
